// File: rtl/dmem_stage_ctrl.sv
// MEM-stage data-memory controller: turns loads/stores into req/ack transactions,
// stalls the front of the pipeline while an access is in flight, and flags errors.
module dmem_stage_ctrl #(
  parameter logic [2:0] OP_LOAD  = 3'b010,
  parameter logic [2:0] OP_STORE = 3'b011,
  parameter int         TIMEOUT  = 16,
  parameter int         CNT_W    = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [31:0]       mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic              rdata_valid_reg, rdata_valid_next;
  logic              err_reg, err_next;

  logic access, misaligned, timeout_hit;

  assign access      = valid_i && ((op_i == OP_LOAD) || (op_i == OP_STORE));
  assign misaligned  = (addr_i[1:0] != 2'b00);
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      mem_req_reg     <= mem_req_next;
      mem_we_reg      <= mem_we_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      rdata_reg       <= rdata_next;
      rdata_valid_reg <= rdata_valid_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    mem_req_next     = mem_req_reg;
    mem_we_next      = mem_we_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    rdata_next       = rdata_reg;
    rdata_valid_next = 1'b0;
    err_next         = 1'b0;
    stall_o          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            err_next = 1'b1;
          end else begin
            stall_o        = 1'b1;
            mem_req_next   = 1'b1;
            mem_we_next    = (op_i == OP_STORE);
            mem_addr_next  = addr_i;
            mem_wdata_next = wdata_i;
            cnt_next       = '0;
            state_next     = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        // An ack in the same cycle as the timeout still completes the access.
        if (mem_ack_i) begin
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (!mem_we_reg) begin
            rdata_next       = mem_rdata_i;
            rdata_valid_next = 1'b1;
          end
          state_next = DONE;
        end else if (timeout_hit) begin
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          err_next     = 1'b1;
          if (!mem_we_reg) begin
            rdata_next = '0;
          end
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      // The completed instruction is still on the inputs here; let it retire.
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rdata_o       = rdata_reg;
  assign rdata_valid_o = rdata_valid_reg;
  assign err_o         = err_reg;
  assign mem_req_o     = mem_req_reg;
  assign mem_we_o      = mem_we_reg;
  assign mem_addr_o    = mem_addr_reg;
  assign mem_wdata_o   = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Self-checking bench for dmem_stage_ctrl: directed cases followed by a random
// instruction mix, checked against a transaction-level model of expected timing.
module tb_dmem_stage_ctrl;

  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam int         TIMEOUT  = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_rdata = '0;

  dmem_stage_ctrl #(
    .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE), .TIMEOUT(TIMEOUT), .CNT_W(5)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_i(op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o), .err_o(err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One aligned load/store presented until it retires. w = BUSY cycles with ack low;
  // w > TIMEOUT means the memory never answers.
  task automatic run_access(input bit is_store, input logic [31:0] addr,
                            input logic [31:0] wdata, input int w, input logic [31:0] mem_val);
    bit tmo;
    int busy_n;
    tmo    = (w > TIMEOUT);
    busy_n = tmo ? TIMEOUT + 1 : w + 1;
    @(posedge clk_i); #1;
    valid_i = 1'b1; op_i = is_store ? OP_STORE : OP_LOAD;
    addr_i = addr; wdata_i = wdata; mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    @(negedge clk_i);
    check("accept_stall", 32'(stall_o), 32'd1);
    check("accept_req", 32'(mem_req_o), 32'd0);
    check("accept_err", 32'(err_o), 32'd0);
    check("accept_rvalid", 32'(rdata_valid_o), 32'd0);
    for (int j = 1; j <= busy_n; j++) begin
      @(posedge clk_i); #1;
      if (!tmo && j == busy_n) begin
        mem_ack_i = 1'b1; mem_rdata_i = mem_val;
      end else begin
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
      end
      @(negedge clk_i);
      check("busy_stall", 32'(stall_o), 32'd1);
      check("busy_req", 32'(mem_req_o), 32'd1);
      check("busy_we", 32'(mem_we_o), 32'(is_store));
      check("busy_addr", mem_addr_o, addr);
      check("busy_wdata", mem_wdata_o, wdata);
      check("busy_err", 32'(err_o), 32'd0);
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    if (!is_store) exp_rdata = tmo ? 32'd0 : mem_val;
    @(negedge clk_i);
    check("done_stall", 32'(stall_o), 32'd0);
    check("done_req", 32'(mem_req_o), 32'd0);
    check("done_rvalid", 32'(rdata_valid_o), 32'(!is_store && !tmo));
    check("done_err", 32'(err_o), 32'(tmo));
    check("done_rdata", rdata_o, exp_rdata);
  endtask

  task automatic run_misaligned(input bit is_store, input logic [31:0] addr);
    @(posedge clk_i); #1;
    valid_i = 1'b1; op_i = is_store ? OP_STORE : OP_LOAD; addr_i = addr; wdata_i = $urandom;
    @(negedge clk_i);
    check("mis_stall", 32'(stall_o), 32'd0);
    check("mis_req", 32'(mem_req_o), 32'd0);
    check("mis_err_early", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    check("mis_err", 32'(err_o), 32'd1);
    check("mis_req_after", 32'(mem_req_o), 32'd0);
    check("mis_rvalid", 32'(rdata_valid_o), 32'd0);
    check("mis_rdata", rdata_o, exp_rdata);
  endtask

  task automatic run_nonmem(input logic valid, input logic [2:0] op);
    @(posedge clk_i); #1;
    valid_i = valid; op_i = op; addr_i = $urandom; wdata_i = $urandom;
    mem_ack_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    check("nonmem_stall", 32'(stall_o), 32'd0);
    check("nonmem_req", 32'(mem_req_o), 32'd0);
    check("nonmem_err", 32'(err_o), 32'd0);
    check("nonmem_rvalid", 32'(rdata_valid_o), 32'd0);
    check("nonmem_rdata", rdata_o, exp_rdata);
    mem_ack_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  nonmem_ops [6];
    logic [31:0] a;
    int          r, w;
    nonmem_ops = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    #2 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_rvalid", 32'(rdata_valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_i = 1'b1;

    run_access(1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    run_access(1'b1, 32'h24, 32'h12345678, 3, 32'h0);
    run_access(1'b0, 32'h30, 32'h0, TIMEOUT + 1, 32'h0);
    run_access(1'b0, 32'h34, 32'h0, TIMEOUT, 32'hCAFEF00D);
    run_misaligned(1'b0, 32'h13);
    run_misaligned(1'b1, 32'h22);
    run_nonmem(1'b1, 3'b000);
    run_access(1'b1, 32'h100, 32'hA5A5A5A5, 1, 32'h0);
    run_access(1'b0, 32'h104, 32'h0, 2, 32'h0BADF00D);
    run_access(1'b1, 32'h108, 32'h5A5A5A5A, TIMEOUT + 2, 32'h0);

    // Reset while an access is in flight.
    @(posedge clk_i); #1;
    valid_i = 1'b1; op_i = OP_LOAD; addr_i = 32'h40; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    valid_i = 1'b0;
    exp_rdata = 32'd0;
    check("midrst_req", 32'(mem_req_o), 32'd0);
    check("midrst_rdata", rdata_o, 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    check("midrst_rvalid", 32'(rdata_valid_o), 32'd0);
    @(negedge clk_i);
    check("midrst_stall", 32'(stall_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("postrst_err", 32'(err_o), 32'd0);
    check("postrst_rvalid", 32'(rdata_valid_o), 32'd0);
    run_access(1'b0, 32'h44, 32'h0, 1, 32'h87654321);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      if (r <= 5) begin
        w = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4)
                                        : $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
        run_access(a[0], {a[31:2], 2'b00}, $urandom, w, $urandom);
      end else if (r <= 7) begin
        run_misaligned(a[0], {a[31:2], 2'($urandom_range(1, 3))});
      end else if (r == 8) begin
        run_nonmem(1'b1, nonmem_ops[$urandom_range(0, 5)]);
      end else begin
        run_nonmem(1'b0, a[0] ? OP_STORE : OP_LOAD);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
